qdr_edge_sampler: RTL and testbench

Multi-lane successor to the single-bit DDR-edge capture. It oversamples one differential DDR clock pair (ClockP/ClockN) and CHANNELS data lanes in the Clock domain. Qualified edges capture one bit per lane per edge (both edges in DDR mode, rising only in SDR mode) and assemble WORD_BITS-bit words per lane. Completed words go into a DEPTH-entry FIFO with a valid/ready output handshake. It sits between the QRAM pin-level nets and the word-level consumer logic.

---
 rtl/qdr_edge_sampler.sv | 183 ++++++++++++++++++
 tb/tb_qdr_edge_sampler.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/qdr_edge_sampler.sv
// Multi-lane DDR/SDR edge sampler: oversamples a differential clock pair, assembles
// per-lane words on qualified edges and queues them in a small valid/ready FIFO.
module qdr_edge_sampler #(
  parameter int CHANNELS   = 4,
  parameter int WORD_BITS  = 8,
  parameter int DEPTH      = 4,
  parameter int GLITCH_MAX = 3
) (
  input  logic                               Clock,
  input  logic                               Reset,
  input  logic                               Enable,
  input  logic                               DdrMode,
  input  logic                               ClearErrors,
  input  logic                               ClockP,
  input  logic                               ClockN,
  input  logic [CHANNELS-1:0]                DataIn,
  output logic [CHANNELS*WORD_BITS-1:0]      DataOut,
  output logic                               Valid,
  input  logic                               Ready,
  output logic [$clog2(DEPTH+1)-1:0]         FillLevel,
  output logic                               Overflow,
  output logic                               PairError
);

  localparam int WORD_W = CHANNELS * WORD_BITS;
  localparam int BIT_W  = $clog2(WORD_BITS);
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int FILL_W = $clog2(DEPTH + 1);
  localparam int RUN_W  = $clog2(GLITCH_MAX + 1);

  localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(WORD_BITS - 1);
  localparam logic [RUN_W-1:0]  RUN_MAX   = RUN_W'(GLITCH_MAX);
  localparam logic [RUN_W-1:0]  RUN_ARM   = RUN_W'(GLITCH_MAX - 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(DEPTH);

  // The incoming bit lands in the MSB and the oldest bit ends up at bit 0, so the
  // partial register only needs the WORD_BITS-1 bits captured so far.
  typedef logic [CHANNELS-1:0][WORD_BITS-2:0] partial_t;
  typedef logic [CHANNELS-1:0][WORD_BITS-1:0] word_t;

  logic                p_meta_q, p_sync_q, n_meta_q, n_sync_q;
  logic [CHANNELS-1:0] data_meta_q, data_sync_q;

  logic                last_pol_q, last_pol_d;
  logic [RUN_W-1:0]    glitch_run_q, glitch_run_d;
  logic [BIT_W-1:0]    bit_cnt_q, bit_cnt_d;
  partial_t            shift_q, shift_d;
  word_t               assembled;

  logic [WORD_W-1:0]   mem_q [DEPTH];
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d, rd_ptr_next;
  logic [FILL_W-1:0]   fill_q, fill_d;
  logic [WORD_W-1:0]   data_out_q, data_out_d;
  logic                overflow_q, overflow_d;
  logic                pair_error_q, pair_error_d;

  logic pair_valid, rise, fall, capture, glitch_hit;
  logic push, push_ok, pop;

  assign pair_valid = p_sync_q ^ n_sync_q;
  assign rise       = pair_valid &  p_sync_q & ~last_pol_q;
  assign fall       = pair_valid & ~p_sync_q &  last_pol_q;
  assign capture    = Enable & (rise | (DdrMode & fall));
  assign glitch_hit = ~pair_valid & (glitch_run_q == RUN_ARM);

  assign Valid       = (fill_q != '0);
  assign pop         = Valid & Ready;
  assign push_ok     = push & ((fill_q != FILL_FULL) | pop);
  assign rd_ptr_next = rd_ptr_q + PTR_W'(1);

  always_ff @(posedge Clock) begin
    // NOTE: every flop uses <= so all registers update from pre-edge values;
    // blocking here would let the synchronizer collapse into a single stage.
    if (Reset) begin
      p_meta_q    <= 1'b0;
      p_sync_q    <= 1'b0;
      n_meta_q    <= 1'b0;
      n_sync_q    <= 1'b0;
      data_meta_q <= '0;
      data_sync_q <= '0;
    end else begin
      p_meta_q    <= ClockP;
      p_sync_q    <= p_meta_q;
      n_meta_q    <= ClockN;
      n_sync_q    <= n_meta_q;
      data_meta_q <= DataIn;
      data_sync_q <= data_meta_q;
    end
  end

  always_comb begin
    // NOTE: each output gets a default before any branch so no path leaves it
    // unassigned, which would otherwise infer a latch.
    last_pol_d   = pair_valid ? p_sync_q : last_pol_q;
    glitch_run_d = glitch_run_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    push         = 1'b0;

    for (int c = 0; c < CHANNELS; c++) begin
      assembled[c] = {data_sync_q[c], shift_q[c]};
    end

    if (pair_valid) begin
      glitch_run_d = '0;
    end else if (glitch_run_q != RUN_MAX) begin
      glitch_run_d = glitch_run_q + RUN_W'(1);
    end

    if (!Enable || glitch_hit) begin
      bit_cnt_d = '0;
    end else if (capture) begin
      for (int c = 0; c < CHANNELS; c++) begin
        shift_d[c] = assembled[c][WORD_BITS-1:1];
      end
      if (bit_cnt_q == LAST_BIT) begin
        bit_cnt_d = '0;
        push      = 1'b1;
      end else begin
        bit_cnt_d = bit_cnt_q + BIT_W'(1);
      end
    end
  end

  always_comb begin
    rd_ptr_d   = pop     ? rd_ptr_next              : rd_ptr_q;
    wr_ptr_d   = push_ok ? wr_ptr_q + PTR_W'(1)     : wr_ptr_q;
    fill_d     = fill_q;
    data_out_d = data_out_q;

    if (push_ok && !pop)      fill_d = fill_q + FILL_W'(1);
    else if (pop && !push_ok) fill_d = fill_q - FILL_W'(1);

    // DataOut always mirrors whatever will be the head after this edge.
    if (pop) begin
      if (fill_q >= FILL_W'(2)) data_out_d = mem_q[rd_ptr_next];
      else if (push_ok)         data_out_d = assembled;
    end else if (!Valid && push_ok) begin
      data_out_d = assembled;
    end

    overflow_d   = (push & ~push_ok) ? 1'b1 : (ClearErrors ? 1'b0 : overflow_q);
    pair_error_d = glitch_hit        ? 1'b1 : (ClearErrors ? 1'b0 : pair_error_q);
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      last_pol_q   <= 1'b0;
      glitch_run_q <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      fill_q       <= '0;
      data_out_q   <= '0;
      overflow_q   <= 1'b0;
      pair_error_q <= 1'b0;
    end else begin
      last_pol_q   <= last_pol_d;
      glitch_run_q <= glitch_run_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      fill_q       <= fill_d;
      data_out_q   <= data_out_d;
      overflow_q   <= overflow_d;
      pair_error_q <= pair_error_d;
    end
  end

  // NOTE: the storage array is deliberately not reset; fill_q alone decides which
  // entries are live, so stale contents are never observed.
  always_ff @(posedge Clock) begin
    if (push_ok) mem_q[wr_ptr_q] <= assembled;
  end

  assign DataOut   = data_out_q;
  assign FillLevel = fill_q;
  assign Overflow  = overflow_q;
  assign PairError = pair_error_q;

endmodule

// File: tb/tb_qdr_edge_sampler.sv
// Directed bench for qdr_edge_sampler: a cycle-level behavioural model (history
// queue, bit-index word build, word queue) checked every cycle, plus literal checks.
module tb_qdr_edge_sampler;

  localparam int CH    = 4;
  localparam int W     = 8;
  localparam int DEPTH = 4;
  localparam int GMAX  = 3;
  localparam int WW    = CH * W;
  localparam int HALF  = 4;

  logic          clk = 1'b0;
  logic          rst, en, ddr, clr, cp, cn, rdy;
  logic [CH-1:0] din;
  logic [WW-1:0] dout;
  logic          valid, ov, pe;
  logic [2:0]    fill;
  logic          cur_p;

  int vectors     = 0;
  int miscompares = 0;

  qdr_edge_sampler #(.CHANNELS(CH), .WORD_BITS(W), .DEPTH(DEPTH), .GLITCH_MAX(GMAX)) dut (
    .Clock(clk), .Reset(rst), .Enable(en), .DdrMode(ddr), .ClearErrors(clr),
    .ClockP(cp), .ClockN(cn), .DataIn(din), .DataOut(dout), .Valid(valid),
    .Ready(rdy), .FillLevel(fill), .Overflow(ov), .PairError(pe)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed { logic p; logic n; logic [CH-1:0] d; } samp_t;

  samp_t         m_hist[$];
  logic [WW-1:0] m_fifo[$];
  logic [WW-1:0] m_word;
  logic          m_last_pol, m_ov, m_pe;
  int            m_run, m_nbits;

  task automatic model_step();
    samp_t cur;
    logic  pv, edge_seen, pop, push, ov_set, pe_set;
    if (rst) begin
      m_hist = '{samp_t'(0), samp_t'(0)};
      m_fifo.delete();
      m_word = '0; m_last_pol = 1'b0; m_ov = 1'b0; m_pe = 1'b0;
      m_run = 0; m_nbits = 0;
      return;
    end
    // A sample taken now is acted upon two edges later.
    cur = m_hist.pop_front();
    m_hist.push_back('{cp, cn, din});
    pop       = (m_fifo.size() > 0) && rdy;
    pv        = (cur.p != cur.n);
    edge_seen = pv && (cur.p != m_last_pol);
    if (pv) m_last_pol = cur.p;
    pe_set = 1'b0;
    push   = 1'b0;
    ov_set = 1'b0;
    if (pv) m_run = 0;
    else if (m_run < GMAX) begin
      m_run++;
      if (m_run == GMAX) begin pe_set = 1'b1; m_nbits = 0; end
    end
    if (!en) m_nbits = 0;
    else if (edge_seen && (cur.p || ddr)) begin
      for (int c = 0; c < CH; c++) m_word[c*W + m_nbits] = cur.d[c];
      m_nbits++;
      if (m_nbits == W) begin push = 1'b1; m_nbits = 0; end
    end
    if (pop) void'(m_fifo.pop_front());
    if (push) begin
      if (m_fifo.size() < DEPTH) m_fifo.push_back(m_word);
      else ov_set = 1'b1;
    end
    m_ov = ov_set ? 1'b1 : (clr ? 1'b0 : m_ov);
    m_pe = pe_set ? 1'b1 : (clr ? 1'b0 : m_pe);
  endtask

  always @(posedge clk) begin
    model_step();
    #1;
    check("model_valid", valid, m_fifo.size() != 0);
    check("model_fill", fill, m_fifo.size());
    check("model_overflow", ov, m_ov);
    check("model_pair_error", pe, m_pe);
    if (m_fifo.size() != 0) check("model_data", dout, m_fifo[0]);
  end

  // ---------------- stimulus helpers ----------------
  function automatic logic [W-1:0] lane_byte(input int w, input int c);
    int v;
    v = w * 37 + c * 11 + 5;
    return v[W-1:0];
  endfunction

  function automatic logic [WW-1:0] full_word(input int w);
    logic [WW-1:0] r;
    for (int c = 0; c < CH; c++) r[c*W +: W] = lane_byte(w, c);
    return r;
  endfunction

  task automatic send_edge(input logic [CH-1:0] d, input int hold);
    cur_p = ~cur_p;
    cp    = cur_p;
    cn    = ~cur_p;
    din   = d;
    repeat (hold) @(negedge clk);
  endtask

  task automatic send_bits(input int w, input int first, input int last, input int last_hold);
    logic [CH-1:0] d;
    logic [W-1:0]  lb;
    for (int b = first; b <= last; b++) begin
      for (int c = 0; c < CH; c++) begin
        lb   = lane_byte(w, c);
        d[c] = lb[b];
      end
      send_edge(d, (b == last) ? last_hold : HALF);
    end
  endtask

  // Called right after the completing edge is driven; Valid is due 3 negedges later.
  task automatic wait_valid(input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!valid && n < 20);
    check(name, n, 3);
  endtask

  task automatic hold_pair(input logic p, input logic n, input int cycles);
    cp = p;
    cn = n;
    repeat (cycles) @(negedge clk);
    cp = cur_p;
    cn = ~cur_p;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [7:0]    t1;
    logic [CH-1:0] d;
    t1  = 8'h4D;
    rst = 1'b1; en = 1'b1; ddr = 1'b1; clr = 1'b0; rdy = 1'b1;
    cp  = 1'b0; cn = 1'b1; cur_p = 1'b0; din = '0;
    repeat (3) @(negedge clk);
    check("reset_valid", valid, 0);
    check("reset_fill", fill, 0);
    check("reset_data", dout, 0);
    check("reset_overflow", ov, 0);
    check("reset_pair_error", pe, 0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // DDR capture: lane0 1,0,1,1,0,0,1,0 and lane3 all ones
    for (int i = 0; i < 8; i++) begin
      d = {1'b1, 2'b00, t1[i]};
      send_edge(d, (i == 7) ? 0 : HALF);
    end
    wait_valid("ddr_latency");
    check("ddr_lane0", dout[7:0], 8'h4D);
    check("ddr_lane3", dout[31:24], 8'hFF);
    repeat (2) @(negedge clk);
    check("ddr_drained", valid, 0);

    // SDR capture: falling edges carry inverted data that must be ignored
    ddr = 1'b0;
    for (int i = 0; i < 8; i++) begin
      d = {1'b1, 2'b00, t1[i]};
      send_edge(d, (i == 7) ? 0 : HALF);
      if (i == 7) begin
        wait_valid("sdr_latency");
        check("sdr_lane0", dout[7:0], 8'h4D);
        check("sdr_lane3", dout[31:24], 8'hFF);
        @(negedge clk);
      end
      send_edge(~d, HALF);
    end
    ddr = 1'b1;

    // Back-pressure: five words into a four-deep FIFO
    rdy = 1'b0;
    for (int w = 1; w <= 5; w++) send_bits(w, 0, W - 1, HALF);
    repeat (4) @(negedge clk);
    check("full_fill", fill, 4);
    check("full_overflow", ov, 1);
    for (int w = 1; w <= 4; w++) begin
      check("drain_order", dout, full_word(w));
      rdy = 1'b1;
      @(negedge clk);
    end
    check("drain_empty", valid, 0);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    check("overflow_cleared", ov, 0);

    // Short glitch mid-word: tolerated
    send_bits(6, 0, 2, HALF);
    hold_pair(1'b1, 1'b1, 2);
    repeat (2) @(negedge clk);
    send_bits(6, 3, W - 1, 0);
    wait_valid("glitch2_latency");
    check("glitch2_word", dout, full_word(6));
    check("glitch2_no_error", pe, 0);
    repeat (HALF) @(negedge clk);

    // Long glitch: pair error, partial word discarded
    send_bits(7, 0, 3, HALF);
    hold_pair(1'b1, 1'b1, 3);
    repeat (4) @(negedge clk);
    check("glitch3_error", pe, 1);
    send_bits(8, 0, W - 1, 0);
    wait_valid("glitch3_latency");
    check("glitch3_clean_word", dout, full_word(8));
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    repeat (HALF) @(negedge clk);
    check("pair_error_cleared", pe, 0);

    // Skew: P rises one cycle before N falls -> exactly one edge
    din   = {lane_byte(9, 3)[0], lane_byte(9, 2)[0], lane_byte(9, 1)[0], lane_byte(9, 0)[0]};
    cp    = 1'b1;
    @(negedge clk);
    cn    = 1'b0;
    cur_p = 1'b1;
    repeat (HALF) @(negedge clk);
    send_bits(9, 1, W - 1, 0);
    wait_valid("skew_latency");
    check("skew_word", dout, full_word(9));
    check("skew_no_error", pe, 0);
    repeat (HALF) @(negedge clk);

    // Enable low drops a partial word
    send_bits(10, 0, 2, HALF);
    en = 1'b0;
    @(negedge clk);
    en = 1'b1;
    send_bits(11, 0, W - 1, 0);
    wait_valid("enable_latency");
    check("enable_word", dout, full_word(11));
    repeat (HALF) @(negedge clk);

    // Reset mid-operation with two words queued and a partial word
    rdy = 1'b0;
    send_bits(12, 0, W - 1, HALF);
    send_bits(13, 0, W - 1, HALF);
    send_bits(14, 0, 4, HALF);
    check("prereset_fill", fill, 2);
    rst   = 1'b1;
    cur_p = 1'b0;
    cp    = 1'b0;
    cn    = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midreset_valid", valid, 0);
    check("midreset_fill", fill, 0);
    check("midreset_overflow", ov, 0);
    check("midreset_pair_error", pe, 0);
    repeat (3) @(negedge clk);
    send_bits(15, 0, W - 1, 0);
    wait_valid("postreset_latency");
    check("postreset_word", dout, full_word(15));
    rdy = 1'b1;
    repeat (3) @(negedge clk);
    check("postreset_drained", valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
